// File: rtl/sram_dual_ctrl_pkg.sv
// Shared encodings for the dual asynchronous SRAM controller.
// Optional macro SRAM_WRITE_VERIFY_EN adds the readback states.
package sram_ctrl_pkg;

  // Controller states
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam logic [2:0] VSETUP  = 3'd4;
  localparam logic [2:0] VSTROBE = 3'd5;
  localparam logic [2:0] VHOLD   = 3'd6;
`endif

  // Operation latched at acceptance
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // addr[16] bank select
  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;

  // Idle level of the active-low SRAM strobes
  localparam logic INACTIVE = 1'b1;

  // 18-bit SRAM address pin value from pad bits and word address
  function automatic logic [17:0] pin_addr(input logic [1:0] pad, input logic [15:0] a);
    return {pad, a};
  endfunction

endpackage

// File: rtl/sram_dual_ctrl_if.sv
// Request/response bundle between a pattern engine and the SRAM controller.
// With SRAM_WRITE_VERIFY_EN defined the bundle carries verify_err.
interface sram_dual_ctrl_if;
  logic        en;
  logic        re;
  logic        we;
  logic [16:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        busy;
`ifdef SRAM_WRITE_VERIFY_EN
  logic        verify_err;

  modport master (output en, re, we, addr, data_in,
                  input  data_out, done, busy, verify_err);
  modport slave  (input  en, re, we, addr, data_in,
                  output data_out, done, busy, verify_err);
`else
  modport master (output en, re, we, addr, data_in,
                  input  data_out, done, busy);
  modport slave  (input  en, re, we, addr, data_in,
                  output data_out, done, busy);
`endif
endinterface

// File: rtl/sram_dual_ctrl_bank_port.sv
// Pin driver for one external SRAM bank: gates the shared strobes with the
// bank select and owns the tristate data bus.
module sram_bank_port
  import sram_ctrl_pkg::*;
(
  input  logic        sel,
  input  logic        en_n,
  input  logic        oe_n,
  input  logic        we_n,
  input  logic        drive,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ram_en,
  output logic        ram_oe,
  output logic        ram_we,
  inout  wire  [15:0] ram_data
);

  // A deselected bank sees every strobe parked inactive and a released bus
  assign ram_en   = sel ? en_n : INACTIVE;
  assign ram_oe   = sel ? oe_n : INACTIVE;
  assign ram_we   = sel ? we_n : INACTIVE;
  assign ram_data = (sel && drive) ? wdata : 16'hzzzz;
  assign rdata    = ram_data;

endmodule

// File: rtl/sram_dual_ctrl.sv
// Responder for re/we/done single-word RAM requests onto two asynchronous
// 16-bit SRAMs; addr[16] picks the bank. Strobes and bus-drive enable are
// registered so the SRAM pins never glitch on state decode.
// Optional macro SRAM_WRITE_VERIFY_EN: each write is followed by a readback
// of the same word and a mismatch raises verify_err.
module sram_dual_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int         STROBE_CYCLES = 2,
  parameter logic [1:0] ADDR_PAD      = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  sram_dual_ctrl_if.slave   bus,
  output logic [17:0]       ram1_addr,
  inout  wire  [15:0]       ram1_data,
  output logic              ram1_en,
  output logic              ram1_oe,
  output logic              ram1_we,
  output logic [17:0]       ram2_addr,
  inout  wire  [15:0]       ram2_data,
  output logic              ram2_en,
  output logic              ram2_oe,
  output logic              ram2_we
);

  localparam logic [2:0] CNT_LOAD = 3'(STROBE_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  cnt;
  logic        op;
  logic        bank;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        re_q;
  logic        we_q;
  logic        re_rise;
  logic        we_rise;
  logic        accept;
  logic        en_n;
  logic        oe_n;
  logic        we_n;
  logic        drive;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic [15:0] rd_data;

  assign re_rise = bus.re & ~re_q;
  assign we_rise = bus.we & ~we_q;
  assign accept  = (state == IDLE) && bus.en && (re_rise || we_rise);
  assign rd_data = (bank == BANK2) ? rd2 : rd1;

  assign ram1_addr = pin_addr(ADDR_PAD, addr_q);
  assign ram2_addr = pin_addr(ADDR_PAD, addr_q);

  // Request edge detectors run every cycle so edges during an access are consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      re_q <= bus.re;
      we_q <= bus.we;
    end
  end

  // Write data is captured only when a write is accepted; it needs no reset
  always_ff @(posedge clk) begin
    if (accept && we_rise)
      wdata_q <= bus.data_in;
  end

  // Access sequencer: SETUP, STROBE (down-counted), HOLD, optional readback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      op           <= RD;
      bank         <= BANK1;
      addr_q       <= 16'h0000;
      en_n         <= INACTIVE;
      oe_n         <= INACTIVE;
      we_n         <= INACTIVE;
      drive        <= 1'b0;
      bus.data_out <= 16'h0000;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
`ifdef SRAM_WRITE_VERIFY_EN
      bus.verify_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op       <= we_rise ? WR : RD;
            addr_q   <= bus.addr[15:0];
            bank     <= bus.addr[16];
            en_n     <= 1'b0;
            drive    <= we_rise;
            bus.done <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SETUP;
`ifdef SRAM_WRITE_VERIFY_EN
            bus.verify_err <= 1'b0;
`endif
          end
        end
        SETUP: begin
          cnt   <= CNT_LOAD;
          state <= STROBE;
          if (op == WR)
            we_n <= 1'b0;
          else
            oe_n <= 1'b0;
        end
        STROBE: begin
          if (cnt == 3'd0) begin
            oe_n  <= INACTIVE;
            we_n  <= INACTIVE;
            state <= HOLD;
            if (op == RD)
              bus.data_out <= rd_data;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        HOLD: begin
          drive <= 1'b0;
`ifdef SRAM_WRITE_VERIFY_EN
          if (op == WR) begin
            state <= VSETUP;
          end else
`endif
          begin
            en_n     <= INACTIVE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef SRAM_WRITE_VERIFY_EN
        VSETUP: begin
          cnt   <= CNT_LOAD;
          oe_n  <= 1'b0;
          state <= VSTROBE;
        end
        VSTROBE: begin
          if (cnt == 3'd0) begin
            oe_n           <= INACTIVE;
            bus.data_out   <= rd_data;
            bus.verify_err <= (rd_data != wdata_q);
            state          <= VHOLD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        VHOLD: begin
          en_n     <= INACTIVE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
`endif
        default: begin
          en_n     <= INACTIVE;
          oe_n     <= INACTIVE;
          we_n     <= INACTIVE;
          drive    <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  sram_bank_port u_bank1 (
    .sel      (bank == BANK1),
    .en_n     (en_n),
    .oe_n     (oe_n),
    .we_n     (we_n),
    .drive    (drive),
    .wdata    (wdata_q),
    .rdata    (rd1),
    .ram_en   (ram1_en),
    .ram_oe   (ram1_oe),
    .ram_we   (ram1_we),
    .ram_data (ram1_data)
  );

  sram_bank_port u_bank2 (
    .sel      (bank == BANK2),
    .en_n     (en_n),
    .oe_n     (oe_n),
    .we_n     (we_n),
    .drive    (drive),
    .wdata    (wdata_q),
    .rdata    (rd2),
    .ram_en   (ram2_en),
    .ram_oe   (ram2_oe),
    .ram_we   (ram2_we),
    .ram_data (ram2_data)
  );

endmodule

// File: tb/tb_sram_dual_ctrl.sv
// Bench for sram_dual_ctrl: two behavioural SRAMs, a word-level reference
// memory, directed cases plus randomized accesses.
module tb_sram_dual_ctrl;
  import sram_ctrl_pkg::*;

  localparam int S    = 2;
  localparam int LAT  = S + 2;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int WLAT = VERIFY ? 2 * LAT : LAT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_dual_ctrl_if bus();

  logic [17:0] ram1_addr, ram2_addr;
  wire  [15:0] ram1_data, ram2_data;
  logic ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we;

  sram_dual_ctrl #(.STROBE_CYCLES(S), .ADDR_PAD(2'b00)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram1_addr(ram1_addr), .ram1_data(ram1_data),
    .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
    .ram2_addr(ram2_addr), .ram2_data(ram2_data),
    .ram2_en(ram2_en), .ram2_oe(ram2_oe), .ram2_we(ram2_we)
  );

  // Behavioural asynchronous SRAMs; rmask models stuck-at-0 read bits
  logic [15:0] mem1 [0:255];
  logic [15:0] mem2 [0:255];
  logic [15:0] rmask = 16'hFFFF;
  assign ram1_data = (!ram1_en && !ram1_oe && ram1_we) ? (mem1[ram1_addr[7:0]] & rmask) : 16'hzzzz;
  assign ram2_data = (!ram2_en && !ram2_oe && ram2_we) ? (mem2[ram2_addr[7:0]] & rmask) : 16'hzzzz;
  always @(negedge clk) begin
    if (!ram1_en && !ram1_we) mem1[ram1_addr[7:0]] <= ram1_data;
    if (!ram2_en && !ram2_we) mem2[ram2_addr[7:0]] <= ram2_data;
  end

  // Reference: word value last written to each 17-bit address
  logic [15:0] refm [int];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One request; wr wins when both wr and rd are raised together
  task automatic access(input bit wr, input bit rd, input logic [16:0] a, input logic [15:0] d);
    int n, we_lo, oe_lo, other_bad, addr_bad, data_bad;
    logic sel, cur_oe, cur_we;
    logic [15:0] cur_data, exp_rb;
    sel = a[16];
    n = 0; we_lo = 0; oe_lo = 0; other_bad = 0; addr_bad = 0; data_bad = 0;
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.we = wr; bus.re = rd;
    @(posedge clk); #1;
    chk("busy_on_accept", 32'(bus.busy), 1);
    while (!bus.done && n < 40) begin
      cur_oe   = sel ? ram2_oe : ram1_oe;
      cur_we   = sel ? ram2_we : ram1_we;
      cur_data = sel ? ram2_data : ram1_data;
      if (!cur_we) begin
        we_lo++;
        if (cur_data !== d) data_bad++;
      end
      if (!cur_oe) oe_lo++;
      if (sel ? !(ram1_en & ram1_oe & ram1_we) : !(ram2_en & ram2_oe & ram2_we)) other_bad++;
      if (ram1_addr != {2'b00, a[15:0]} || ram2_addr != {2'b00, a[15:0]}) addr_bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), wr ? WLAT : LAT);
    chk("we_low_cycles", 32'(we_lo), wr ? S : 0);
    chk("oe_low_cycles", 32'(oe_lo), (!wr || VERIFY) ? S : 0);
    chk("other_bank_idle", 32'(other_bad), 0);
    chk("addr_pins", 32'(addr_bad), 0);
    chk("wr_bus_data", 32'(data_bad), 0);
    chk("busy_off", 32'(bus.busy), 0);
    if (wr) begin
      refm[int'(a)] = d;
`ifdef SRAM_WRITE_VERIFY_EN
      exp_rb = d & rmask;
      chk("verify_data", 32'(bus.data_out), 32'(exp_rb));
      chk("verify_err", 32'(bus.verify_err), 32'(exp_rb != d));
`endif
    end else begin
      exp_rb = refm[int'(a)];
      chk("read_data", 32'(bus.data_out), 32'(exp_rb));
`ifdef SRAM_WRITE_VERIFY_EN
      chk("verify_err_clr", 32'(bus.verify_err), 0);
`endif
    end
    @(negedge clk);
    bus.re = 1'b0; bus.we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int rises, falls, en_lo;
    logic pd, pe;
    logic [16:0] a;
    bit w;
    bus.en = 1'b1; bus.re = 1'b0; bus.we = 1'b0;
    bus.addr = '0; bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", 32'({ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we}), 32'h3F);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_addr", 32'(ram1_addr), 0);
    @(negedge clk); rst = 1'b1;

    // Basic write/read on RAM1
    access(1, 0, 17'h00005, 16'h1234);
    access(0, 1, 17'h00005, 16'h0000);
    // Bank isolation
    access(1, 0, 17'h10005, 16'hBEEF);
    access(1, 0, 17'h00005, 16'h0001);
    access(0, 1, 17'h10005, 16'h0000);
    access(0, 1, 17'h00005, 16'h0000);
    // Simultaneous re/we: write only
    access(1, 1, 17'h00009, 16'h00AA);
    access(0, 1, 17'h00009, 16'h0000);

    // re held high with a second pulse while busy: one access only
    rises = 0; falls = 0;
    @(negedge clk);
    pd = bus.done; pe = ram1_en & ram2_en;
    bus.addr = 17'h00009; bus.re = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) bus.re = 1'b0;
      if (i == 3) bus.re = 1'b1;
      if (bus.done && !pd) rises++;
      if (!(ram1_en & ram2_en) && pe) falls++;
      pd = bus.done; pe = ram1_en & ram2_en;
    end
    chk("hold_done_rises", 32'(rises), 1);
    chk("hold_accesses", 32'(falls), 1);
    chk("hold_data", 32'(bus.data_out), 32'h00AA);
    bus.re = 1'b0;

    // en low blocks acceptance
    @(negedge clk); bus.en = 1'b0; bus.addr = 17'h00005; bus.re = 1'b1;
    en_lo = 0;
    repeat (6) begin
      @(negedge clk);
      if (!(ram1_en & ram2_en)) en_lo++;
    end
    chk("en_off_no_access", 32'(en_lo), 0);
    chk("en_off_busy", 32'(bus.busy), 0);
    bus.re = 1'b0;
    @(negedge clk); bus.en = 1'b1;

    // Randomized accesses over a small address set in both banks
    for (int i = 0; i < 30; i++) begin
      a = {1'($urandom_range(0, 1)), 16'($urandom_range(0, 15))};
      w = 1'($urandom_range(0, 1));
      if (!refm.exists(int'(a))) w = 1'b1;
      if (w) access(1, 0, a, 16'($urandom));
      else   access(0, 1, a, 16'h0000);
    end

    // Reset during the write strobe
    @(negedge clk); bus.addr = 17'h00030; bus.data_in = 16'h5A5A; bus.we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_pre_we", 32'(ram1_we), 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_pins", 32'({ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we}), 32'h3F);
    chk("rst_mid_done", 32'(bus.done), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_data_out", 32'(bus.data_out), 0);
    bus.we = 1'b0;
    @(negedge clk); rst = 1'b1;
    access(0, 1, 17'h00005, 16'h0000);

`ifdef SRAM_WRITE_VERIFY_EN
    // Readback with bit 0 stuck at 0
    rmask = 16'hFFFE;
    access(1, 0, 17'h00020, 16'h0003);
    rmask = 16'hFFFF;
    access(0, 1, 17'h00020, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
